// File: rtl/multi_matmul_feeder_pkg.sv
// Shared types and sizing helpers for the multi_matmul operand feeder.
package mha_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        FEED      = 2'd2,
        WAIT_DONE = 2'd3
    } feeder_state_e;

    function automatic int k_steps(input int inner_dim, input int block);
        return inner_dim / block;
    endfunction

    // Wide enough to hold K_STEPS itself, not just K_STEPS-1.
    function automatic int step_width(input int inner_dim, input int block);
        return $clog2(k_steps(inner_dim, block) + 1);
    endfunction

endpackage

// File: rtl/multi_matmul_feeder_lane_reg.sv
// One west-lane operand register; loads on an accepted slice, otherwise holds.
module feeder_lane_reg #(
    parameter int W = 256
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] lane_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= '0;
        end else if (load_i) begin
            lane_q <= d_i;
        end
    end

    assign q_o = lane_q;

endmodule

// File: rtl/multi_matmul_feeder.sv
// Tile sequencer feeding west/north operand slices into multi_matmul_wrapper.
// Optional stall/done-wait counters are built when MULTI_MATMUL_FEEDER_STALL_STATS_EN is defined.
module multi_matmul_feeder
    import mha_feeder_pkg::*;
#(
    parameter int WIDTH_A         = 16,
    parameter int WIDTH_B         = 16,
    parameter int CHUNK_SIZE      = 4,
    parameter int NUM_CORES_A     = 4,
    parameter int NUM_CORES_B     = 1,
    parameter int TOTAL_MODULES   = 2,
    parameter int TOTAL_INPUT_W   = 2,
    parameter int BLOCK_SIZE      = 2,
    parameter int INNER_DIMENSION = 64,
    localparam int WA = WIDTH_A * CHUNK_SIZE * NUM_CORES_A,
    localparam int WN = WIDTH_B * CHUNK_SIZE * NUM_CORES_B * TOTAL_MODULES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WA*TOTAL_INPUT_W-1:0] s_w_data,
    input  logic [WN-1:0]              s_n_data,
    input  logic                       acc_done_wrap,
    output logic                       en,
    output logic                       reset_acc,
    output logic [WA-1:0]              input_w [TOTAL_INPUT_W],
    output logic [WN-1:0]              input_n,
    output logic                       busy,
    output logic                       tile_done,
    output logic [1:0]                 state_dbg,
    output logic [15:0]                tile_count
`ifdef MULTI_MATMUL_FEEDER_STALL_STATS_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [15:0]                done_wait_cycles
`endif
);

    localparam int KS = k_steps(INNER_DIMENSION, BLOCK_SIZE);
    localparam int SW = step_width(INNER_DIMENSION, BLOCK_SIZE);
    localparam logic [SW-1:0] LAST_STEP = SW'(KS - 1);

    if (INNER_DIMENSION % BLOCK_SIZE != 0) begin : g_bad_dim
        $error("INNER_DIMENSION must be a multiple of BLOCK_SIZE");
    end

    feeder_state_e state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic          en_q;
    logic          tile_done_q;
    logic [15:0]   tile_count_q;
    logic [WN-1:0] input_n_q;
    logic          xfer;
    logic          retire;

    // Handshake: a slice moves on any cycle with s_valid && s_ready; s_ready is
    // a pure function of state so the source may raise s_valid at will.
    assign xfer   = (state_q == FEED) && s_valid;
    assign retire = (state_q == WAIT_DONE) && acc_done_wrap;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        unique case (state_q)
            IDLE: begin
                // tile_done_q marks the retire cycle; a start there is dropped.
                if (start && !tile_done_q) state_d = CLEAR;
            end
            CLEAR: begin
                step_d  = '0;
                state_d = FEED;
            end
            FEED: begin
                if (xfer) begin
                    step_d = step_q + SW'(1);
                    if (step_q == LAST_STEP) state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (acc_done_wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            step_q       <= '0;
            en_q         <= 1'b0;
            tile_done_q  <= 1'b0;
            tile_count_q <= '0;
            input_n_q    <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            en_q        <= xfer;
            tile_done_q <= retire;
            if (retire) tile_count_q <= tile_count_q + 16'd1;
            if (xfer) input_n_q <= s_n_data;
        end
    end

    for (genvar g = 0; g < TOTAL_INPUT_W; g++) begin : g_lane
        feeder_lane_reg #(
            .W(WA)
        ) u_lane (
            .clk_i (clk),
            .rst_ni(rst_n),
            .load_i(xfer),
            .d_i   (s_w_data[g*WA +: WA]),
            .q_o   (input_w[g])
        );
    end

`ifdef MULTI_MATMUL_FEEDER_STALL_STATS_EN
    logic [31:0] stall_q;
    logic [15:0] dwait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            dwait_q <= '0;
        end else if (state_q == CLEAR) begin
            stall_q <= '0;
            dwait_q <= '0;
        end else begin
            if ((state_q == FEED) && !s_valid && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
            if ((state_q == WAIT_DONE) && (dwait_q != 16'hFFFF)) dwait_q <= dwait_q + 16'd1;
        end
    end

    assign stall_cycles     = stall_q;
    assign done_wait_cycles = dwait_q;
`endif

    assign s_ready    = (state_q == FEED);
    assign reset_acc  = (state_q == CLEAR);
    assign busy       = (state_q != IDLE);
    assign en         = en_q;
    assign tile_done  = tile_done_q;
    assign tile_count = tile_count_q;
    assign input_n    = input_n_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/multi_matmul_feeder.md
Name: multi_matmul_feeder

Overview:
- Transmit side of the multi_matmul_wrapper operand interface: sequences one output tile at a time.
- Accepts a combined valid/ready stream of west (per-instance) and north (shared) operand slices and registers them onto the wrapper's input_w/input_n buses.
- Generates en and reset_acc toward the wrapper and waits on acc_done_wrap before retiring each tile.
- Sits between the operand fetch/DMA logic and multi_matmul_wrapper in the Multi-Head Attention datapath.

Parameters:
WIDTH_A, 16, west element width
WIDTH_B, 16, north element width
CHUNK_SIZE, 4, elements per core chunk
NUM_CORES_A, 4, west cores per instance
NUM_CORES_B, 1, north cores per module
TOTAL_MODULES, 2, modules per multi_matmul
TOTAL_INPUT_W, 2, multi_matmul instances (west lanes)
BLOCK_SIZE, 2, systolic block size
INNER_DIMENSION, 64, reduction length; K_STEPS = INNER_DIMENSION/BLOCK_SIZE (default 32)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a tile
s_valid  in  1  operand slice valid
s_ready  out  1  operand slice accepted when s_valid&&s_ready
s_w_data  in  WA*TOTAL_INPUT_W  packed west slices; WA = WIDTH_A*CHUNK_SIZE*NUM_CORES_A; lane i = bits [i*WA +: WA]
s_n_data  in  WIDTH_B*CHUNK_SIZE*NUM_CORES_B*TOTAL_MODULES  shared north slice
acc_done_wrap  in  1  wrapper accumulation complete
en  out  1  wrapper enable, one cycle per accepted slice
reset_acc  out  1  wrapper accumulator clear
input_w  out  [WA-1:0] x TOTAL_INPUT_W (unpacked)  per-instance west operand
input_n  out  north width  shared north operand
busy  out  1  high from start acceptance until tile_done
tile_done  out  1  one-cycle pulse when a tile retires
tile_count  out  16  tiles retired, wraps 0xFFFF->0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; en=0, reset_acc=0, s_ready=0, busy=0, tile_done=0, tile_count=0, input_w/input_n=0, step counter=0.
- FSM states: IDLE -> CLEAR -> FEED -> WAIT_DONE -> IDLE.
- IDLE: s_ready=0. start=1 -> CLEAR. busy rises the cycle after start.
- CLEAR: reset_acc=1 for exactly this cycle; step counter cleared; -> FEED.
- FEED:
  - s_ready=1 (depends only on state, never on s_valid).
  - On a transfer, capture s_w_data lanes into input_w[i] and s_n_data into input_n.
  - en=1 in the following cycle only; step counter increments.
  - No transfer -> en=0 next cycle; input_w/input_n hold their values.
  - On the transfer with step==K_STEPS-1, s_ready drops the next cycle -> WAIT_DONE.
  - Latency: transfer to en = 1 cycle. Back-to-back transfers give continuous en.
- WAIT_DONE: s_ready=0.
  - acc_done_wrap=1 -> tile_done=1 for one cycle, tile_count+1, busy=0, -> IDLE.
  - acc_done_wrap sampled only in WAIT_DONE; a high level in other states is ignored.
- start while busy is ignored (not queued).
- start asserted on the same cycle as tile_done is ignored; start must come from IDLE.
- Reset mid-tile aborts immediately to the reset values. No partial tile_done.
- Output operand registers hold their last values after a tile; they are not cleared.

Optional Feature:
- Macro MULTI_MATMUL_FEEDER_STALL_STATS_EN.
- Defined:
  - Adds output stall_cycles (32 bits), counting FEED cycles with s_ready=1 and s_valid=0.
  - Saturates at 0xFFFFFFFF; cleared on reset and on each CLEAR entry.
  - Also adds output done_wait_cycles (16 bits), counting WAIT_DONE cycles for the current tile.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package mha_feeder_pkg: state enum typedef (IDLE, CLEAR, FEED, WAIT_DONE) and a function computing K_STEPS plus step counter width $clog2(K_STEPS+1).
- Sub-module feeder_lane_reg: one west lane register with load enable, instantiated TOTAL_INPUT_W times via generate.
- Elaboration check: INNER_DIMENSION % BLOCK_SIZE == 0.

Test Plan:
- Reset/idle: assert rst_n=0 mid-simulation -> en=0, reset_acc=0, s_ready=0, tile_count=0 asynchronously, before the next clk edge.
- Nominal tile: start, then 32 back-to-back slices with lane0=0x1..., lane1=0x2... -> reset_acc one cycle, then 32 consecutive en pulses each one cycle after its transfer carrying matching data; acc_done_wrap after 5 cycles -> tile_done pulse, tile_count=1.
- Throttled source: s_valid toggled every other cycle -> exactly 32 en pulses; input_w stable between pulses; (with macro) stall_cycles=31.
- Done gating: hold acc_done_wrap=1 during FEED -> no early retire; drop it and raise it 10 cycles into WAIT_DONE -> tile_done exactly then; s_ready=0 throughout WAIT_DONE.
- Start while busy: pulse start at step 5 -> ignored; one tile only, tile_count increments by 1.
- Abort and wrap: rst_n low at step 17, then a full tile -> clean reset_acc and 32 en; preload tile_count to 0xFFFF via 65535 tiles (fast-forward) -> wraps to 0.
